// File: rtl/cpu_pkg.sv
// Types shared by the CPU data-memory arbiter and its round-robin helper.
package cpu_pkg;

  typedef enum logic {OWN_CPU = 1'b0, OWN_ACC = 1'b1} mem_owner_t;

  typedef enum logic {ARB_IDLE = 1'b0, ARB_WAIT = 1'b1} arb_state_t;

  // Request/grant vector bit positions.
  localparam int unsigned REQ_CPU = 0;
  localparam int unsigned REQ_ACC = 1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: on a tie the requester that did not win last time wins.
module rr_arb2
  import cpu_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       adv,
  output logic [1:0] gnt
);

  mem_owner_t last_q, last_d;

  always_comb begin
    gnt = 2'b00;
    unique case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (last_q == OWN_ACC) ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

  always_comb begin
    last_d = last_q;
    if (adv && (gnt != 2'b00)) begin
      last_d = gnt[REQ_ACC] ? OWN_ACC : OWN_CPU;
    end
  end

  // Reset to ACC so the CPU wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= OWN_ACC;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/cpu_datamem_arbiter.sv
// Shares the single-port data memory between CPU load/store and the accelerator master.
// One access in flight; reads wait MEM_LAT cycles, writes complete in their issue cycle.
module cpu_datamem_arbiter
  import cpu_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_rd,
  input  logic              cpu_wr,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_stall,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_rvalid,
  input  logic              acc_req,
  input  logic              acc_we,
  input  logic [ADDR_W-1:0] acc_addr,
  input  logic [DATA_W-1:0] acc_wdata,
  output logic              acc_gnt,
  output logic [DATA_W-1:0] acc_rdata,
  output logic              acc_rvalid,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned LatW = $clog2(MEM_LAT + 1);
  localparam logic [LatW-1:0] LatInit = LatW'(MEM_LAT - 1);

  arb_state_t      state_q, state_d;
  mem_owner_t      owner_q, owner_d;
  logic [LatW-1:0] lat_cnt_q, lat_cnt_d;

  logic       cpu_req;
  logic [1:0] req;
  logic [1:0] gnt;
  logic       issue;
  logic       issue_we;
  logic       complete;
  logic       cpu_done;

  assign cpu_req = cpu_rd | cpu_wr;
  assign req     = {acc_req, cpu_req};

  // Outputs are forced low while reset is asserted, so every decode is qualified by rst_n.
  assign issue    = rst_n && (state_q == ARB_IDLE) && (req != 2'b00);
  assign issue_we = gnt[REQ_ACC] ? acc_we : cpu_wr;
  assign complete = rst_n && (state_q == ARB_WAIT) && (lat_cnt_q == '0);

  rr_arb2 u_rr_arb2 (
    .clk  (clk),
    .rst_n(rst_n),
    .req  (req),
    .adv  (issue),
    .gnt  (gnt)
  );

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    lat_cnt_d = lat_cnt_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (issue && !issue_we) begin
          state_d   = ARB_WAIT;
          lat_cnt_d = LatInit;
          owner_d   = gnt[REQ_ACC] ? OWN_ACC : OWN_CPU;
        end
      end
      ARB_WAIT: begin
        if (lat_cnt_q == '0) begin
          state_d = ARB_IDLE;
        end else begin
          lat_cnt_d = lat_cnt_q - LatW'(1);
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ARB_IDLE;
      owner_q   <= OWN_ACC;
      lat_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      lat_cnt_q <= lat_cnt_d;
    end
  end

  always_comb begin
    mem_en    = issue;
    mem_we    = issue && issue_we;
    mem_addr  = '0;
    mem_wdata = '0;
    if (issue) begin
      mem_addr  = gnt[REQ_ACC] ? acc_addr : cpu_addr;
      mem_wdata = gnt[REQ_ACC] ? acc_wdata : cpu_wdata;
    end
  end

  always_comb begin
    acc_gnt    = issue && gnt[REQ_ACC];
    cpu_rvalid = complete && (owner_q == OWN_CPU);
    acc_rvalid = complete && (owner_q == OWN_ACC);
    cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
    acc_rdata  = acc_rvalid ? mem_rdata : '0;
  end

  // The CPU gets exactly one stall-free cycle per access: write issue or read completion.
  assign cpu_done  = (issue && gnt[REQ_CPU] && cpu_wr) || cpu_rvalid;
  assign cpu_stall = rst_n && cpu_req && !cpu_done;

endmodule

// File: tb/tb_cpu_datamem_arbiter.sv
// Directed bench: dut_a (MEM_LAT=2) runs the vector table and corner sequences,
// dut_b (MEM_LAT=1) shares the stimulus and covers back-to-back single-latency reads.
module tb_cpu_datamem_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        cpu_rd, cpu_wr, acc_req, acc_we;
  logic [31:0] cpu_addr, cpu_wdata, acc_addr, acc_wdata;

  logic        a_cpu_stall, a_cpu_rvalid, a_acc_gnt, a_acc_rvalid, a_mem_en, a_mem_we;
  logic [31:0] a_cpu_rdata, a_acc_rdata, a_mem_addr, a_mem_wdata, a_mem_rdata;
  logic        b_cpu_stall, b_cpu_rvalid, b_acc_gnt, b_acc_rvalid, b_mem_en, b_mem_we;
  logic [31:0] b_cpu_rdata, b_acc_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;

  cpu_datamem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_stall(a_cpu_stall), .cpu_rdata(a_cpu_rdata), .cpu_rvalid(a_cpu_rvalid),
    .acc_req(acc_req), .acc_we(acc_we), .acc_addr(acc_addr), .acc_wdata(acc_wdata),
    .acc_gnt(a_acc_gnt), .acc_rdata(a_acc_rdata), .acc_rvalid(a_acc_rvalid),
    .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
    .mem_rdata(a_mem_rdata)
  );

  cpu_datamem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_stall(b_cpu_stall), .cpu_rdata(b_cpu_rdata), .cpu_rvalid(b_cpu_rvalid),
    .acc_req(acc_req), .acc_we(acc_we), .acc_addr(acc_addr), .acc_wdata(acc_wdata),
    .acc_gnt(b_acc_gnt), .acc_rdata(b_acc_rdata), .acc_rvalid(b_acc_rvalid),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_rdata(b_mem_rdata)
  );

  // Memory models: 16 words, word i preset to C0DE000i except word 3 (addr 0xC) = 0x1234.
  logic [31:0] mem_a [16];
  logic [31:0] mem_b [16];
  logic [31:0] pa1, pa2, pb1;

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) mem_a[i] <= 32'hC0DE0000 | 32'(i);
      mem_a[3] <= 32'h1234;
    end else if (a_mem_en && a_mem_we) begin
      mem_a[a_mem_addr[5:2]] <= a_mem_wdata;
    end
    if (a_mem_en && !a_mem_we) pa1 <= mem_a[a_mem_addr[5:2]];
    pa2 <= pa1;
  end

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) mem_b[i] <= 32'hC0DE0000 | 32'(i);
      mem_b[3] <= 32'h1234;
    end else if (b_mem_en && b_mem_we) begin
      mem_b[b_mem_addr[5:2]] <= b_mem_wdata;
    end
    if (b_mem_en && !b_mem_we) pb1 <= mem_b[b_mem_addr[5:2]];
  end

  assign a_mem_rdata = pa2;
  assign b_mem_rdata = pb1;

  logic [133:0] a_out, b_out;
  assign a_out = {a_cpu_stall, a_cpu_rvalid, a_cpu_rdata, a_acc_gnt, a_acc_rvalid, a_acc_rdata,
                  a_mem_en, a_mem_we, a_mem_addr, a_mem_wdata};
  assign b_out = {b_cpu_stall, b_cpu_rvalid, b_cpu_rdata, b_acc_gnt, b_acc_rvalid, b_acc_rdata,
                  b_mem_en, b_mem_we, b_mem_addr, b_mem_wdata};

  // Expected bundle: stall, cpu_rvalid, cpu_rdata, acc_gnt, acc_rvalid, acc_rdata, en, we, addr, wdata
  function automatic logic [133:0] mk(input logic [31:0] st, crv, crd, gnt, arv, ard,
                                      en, we, addr, wd);
    return {st[0], crv[0], crd, gnt[0], arv[0], ard, en[0], we[0], addr, wd};
  endfunction

  typedef struct {
    logic        cpu_rd;
    logic        cpu_wr;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        acc_req;
    logic        acc_we;
    logic [31:0] acc_addr;
    logic [31:0] acc_wdata;
    logic [133:0] exp;
  } vec_t;

  vec_t tbl[$];
  int n_vec = 0;
  int n_bad = 0;

  task automatic add(input logic [31:0] cr, cw, ca, cd, ar, aw, aa, ad, input logic [133:0] e);
    vec_t v;
    v.cpu_rd = cr[0]; v.cpu_wr = cw[0]; v.cpu_addr = ca; v.cpu_wdata = cd;
    v.acc_req = ar[0]; v.acc_we = aw[0]; v.acc_addr = aa; v.acc_wdata = ad;
    v.exp = e;
    tbl.push_back(v);
  endtask

  task automatic drive(input logic [31:0] cr, cw, ca, cd, ar, aw, aa, ad);
    cpu_rd = cr[0]; cpu_wr = cw[0]; cpu_addr = ca; cpu_wdata = cd;
    acc_req = ar[0]; acc_we = aw[0]; acc_addr = aa; acc_wdata = ad;
  endtask

  task automatic check(input string nm, input logic [133:0] act, input logic [133:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  localparam logic [133:0] Z = '0;

  initial begin
    // Table for dut_a (MEM_LAT=2), starting right after reset.
    add(0, 1, 'h10, 'hDEADBEEF, 0, 0, 0, 0, mk(0, 0, 0, 0, 0, 0, 1, 1, 'h10, 'hDEADBEEF));
    add(1, 0, 'hC, 0, 0, 0, 0, 0, mk(1, 0, 0, 0, 0, 0, 1, 0, 'hC, 0));
    add(1, 0, 'hC, 0, 0, 0, 0, 0, mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    add(1, 0, 'hC, 0, 0, 0, 0, 0, mk(0, 1, 'h1234, 0, 0, 0, 0, 0, 0, 0));
    add(0, 0, 0, 0, 0, 0, 0, 0, Z);
    // Tie after two CPU wins goes to acc; CPU store then waits out the acc read.
    add(0, 1, 'h14, 'h55, 1, 0, 'h10, 0, mk(1, 0, 0, 1, 0, 0, 1, 0, 'h10, 0));
    add(0, 1, 'h14, 'h55, 0, 0, 0, 0, mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    add(0, 1, 'h14, 'h55, 0, 0, 0, 0, mk(1, 0, 0, 0, 1, 'hDEADBEEF, 0, 0, 0, 0));
    add(0, 1, 'h14, 'h55, 0, 0, 0, 0, mk(0, 0, 0, 0, 0, 0, 1, 1, 'h14, 'h55));
    add(0, 0, 0, 0, 1, 1, 'h18, 'hA, mk(0, 0, 0, 1, 0, 0, 1, 1, 'h18, 'hA));
    add(0, 0, 0, 0, 1, 0, 'h14, 0, mk(0, 0, 0, 1, 0, 0, 1, 0, 'h14, 0));
    add(0, 0, 0, 0, 0, 0, 0, 0, Z);
    add(0, 0, 0, 0, 0, 0, 0, 0, mk(0, 0, 0, 0, 1, 'h55, 0, 0, 0, 0));
    add(0, 0, 0, 0, 0, 0, 0, 0, Z);

    // Outputs stay low in reset even with both requesters active.
    drive(1, 0, 'h8, 0, 1, 1, 'h4, 'h99);
    rst_n = 1'b0;
    #4;
    check("reset_a", a_out, Z);
    check("reset_b", b_out, Z);
    tick();
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      drive(32'(tbl[i].cpu_rd), 32'(tbl[i].cpu_wr), tbl[i].cpu_addr, tbl[i].cpu_wdata,
            32'(tbl[i].acc_req), 32'(tbl[i].acc_we), tbl[i].acc_addr, tbl[i].acc_wdata);
      #4;
      check($sformatf("vec%0d", i), a_out, tbl[i].exp);
      tick();
    end

    // Four consecutive ties from reset alternate CPU, acc, CPU, acc.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      drive(0, 1, 'h20, 'h11, 1, 1, 'h24, 'h22);
      #4;
      if (k % 2 == 0) check($sformatf("tie%0d", k), a_out, mk(0, 0, 0, 0, 0, 0, 1, 1, 'h20, 'h11));
      else check($sformatf("tie%0d", k), a_out, mk(1, 0, 0, 1, 0, 0, 1, 1, 'h24, 'h22));
      tick();
    end

    // Reset while an acc read is in WAIT drops it; the next request issues normally.
    do_reset();
    drive(0, 0, 0, 0, 1, 0, 'h0, 0);
    #4;
    check("rst_issue", a_out, mk(0, 0, 0, 1, 0, 0, 1, 0, 0, 0));
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    #3;
    check("rst_mid", a_out, Z);
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      #4;
      check($sformatf("rst_drop%0d", k), a_out, Z);
      tick();
    end
    drive(0, 0, 0, 0, 1, 0, 'h4, 0);
    #4;
    check("rst_reissue", a_out, mk(0, 0, 0, 1, 0, 0, 1, 0, 'h4, 0));
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #4;
    check("rst_wait", a_out, Z);
    tick();
    #4;
    check("rst_rvalid", a_out, mk(0, 0, 0, 0, 1, 'hC0DE0001, 0, 0, 0, 0));
    tick();

    // dut_b (MEM_LAT=1): acc holds req across two reads, granted every second cycle.
    do_reset();
    drive(0, 0, 0, 0, 1, 0, 'h0, 0);
    #4;
    check("b2b_gnt0", b_out, mk(0, 0, 0, 1, 0, 0, 1, 0, 'h0, 0));
    tick();
    drive(0, 0, 0, 0, 1, 0, 'h4, 0);
    #4;
    check("b2b_rv0", b_out, mk(0, 0, 0, 0, 1, 'hC0DE0000, 0, 0, 0, 0));
    tick();
    #4;
    check("b2b_gnt1", b_out, mk(0, 0, 0, 1, 0, 0, 1, 0, 'h4, 0));
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #4;
    check("b2b_rv1", b_out, mk(0, 0, 0, 0, 1, 'hC0DE0001, 0, 0, 0, 0));
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
